ft_host_out_arbiter: RTL and testbench

Shares the outgoing host path of the FT245 host interface (`oh_ready`/`oh_en`/`out_*`) between two response sources:
- port 0: the wishbone master's read/write/ping responses;
- port 1: an interrupt/event reporter.

It grants one requester per packet with round-robin fairness and registers every header and data field toward the host interface. It runs the host interface's one-cycle `oh_en` pulse handshake, retrying rejected beats, and aborts stalled packets via a watchdog.

---
 rtl/ft_host_out_arbiter_if.sv | 31 +++
 rtl/ft_host_out_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_ft_host_out_arbiter.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ft_host_out_arbiter_if.sv
// Bundles shared by the outgoing host-path arbiter: one response requester
// port, and the FT245 outgoing host path.
interface ft_host_out_req_if;
  logic        req;
  logic [31:0] status;
  logic [31:0] address;
  logic [27:0] data_count;
  logic [31:0] data;
  logic        dvalid;
  logic        ack;
  logic        done;

  modport master (output req, status, address, data_count, data, dvalid,
                  input  ack, done);
  modport slave  (input  req, status, address, data_count, data, dvalid,
                  output ack, done);
endinterface

interface ft_host_out_oh_if;
  logic        oh_ready;
  logic        oh_en;
  logic [31:0] out_status;
  logic [31:0] out_address;
  logic [27:0] out_data_count;
  logic [31:0] out_data;

  modport master (input  oh_ready,
                  output oh_en, out_status, out_address, out_data_count, out_data);
  modport slave  (output oh_ready,
                  input  oh_en, out_status, out_address, out_data_count, out_data);
endinterface

// File: rtl/ft_host_out_arbiter.sv
// Round-robin arbiter sharing the FT245 outgoing host path between two
// response sources, with oh_en pulse handshake, retry and stall watchdog.
module ft_host_out_arbiter #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  ft_host_out_req_if.slave r0_i,
  ft_host_out_req_if.slave r1_i,
  ft_host_out_oh_if.master oh_o,
  output logic [1:0]       gnt_o,
  output logic             err_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_RDY,
    S_ISSUED,
    S_CHECK,
    S_NEXT
  } state_t;

  localparam bit          WDOG_EN   = (TIMEOUT != 0);
  localparam logic [31:0] WDOG_LAST = 32'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [1:0]  gnt_q, gnt_d;
  logic        last_gnt_q, last_gnt_d;
  logic        sel_q, sel_d;
  logic [27:0] remaining_q, remaining_d;
  logic [27:0] loaded_q, loaded_d;
  logic [31:0] wdog_q, wdog_d;
  logic        oh_en_q, oh_en_d;
  logic [31:0] out_status_q, out_status_d;
  logic [31:0] out_address_q, out_address_d;
  logic [27:0] out_count_q, out_count_d;
  logic [31:0] out_data_q, out_data_d;
  logic [1:0]  ack_q, ack_d;
  logic [1:0]  done_q, done_d;
  logic        err_q, err_d;

  logic [1:0]  req;
  logic [1:0]  dvalid;
  logic [31:0] status  [2];
  logic [31:0] address [2];
  logic [27:0] count   [2];
  logic [31:0] data    [2];

  assign req        = {r1_i.req, r0_i.req};
  assign dvalid     = {r1_i.dvalid, r0_i.dvalid};
  assign status[0]  = r0_i.status;
  assign status[1]  = r1_i.status;
  assign address[0] = r0_i.address;
  assign address[1] = r1_i.address;
  assign count[0]   = r0_i.data_count;
  assign count[1]   = r1_i.data_count;
  assign data[0]    = r0_i.data;
  assign data[1]    = r1_i.data;

  // On a tie the port that did not win last time is served.
  logic win;
  logic win_vld;
  always_comb begin
    win     = 1'b0;
    win_vld = 1'b0;
    if (req[0] && req[1]) begin
      win     = ~last_gnt_q;
      win_vld = 1'b1;
    end else if (req[0]) begin
      win     = 1'b0;
      win_vld = 1'b1;
    end else if (req[1]) begin
      win     = 1'b1;
      win_vld = 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    last_gnt_d    = last_gnt_q;
    sel_d         = sel_q;
    remaining_d   = remaining_q;
    loaded_d      = loaded_q;
    wdog_d        = wdog_q;
    oh_en_d       = 1'b0;
    out_status_d  = out_status_q;
    out_address_d = out_address_q;
    out_count_d   = out_count_q;
    out_data_d    = out_data_q;
    ack_d         = 2'b00;
    done_d        = 2'b00;
    err_d         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          sel_d         = win;
          gnt_d         = win ? 2'b10 : 2'b01;
          last_gnt_d    = win;
          out_status_d  = status[win];
          out_address_d = address[win];
          out_count_d   = count[win];
          wdog_d        = '0;
          if (status[win][7:0] == 8'hFD) begin
            remaining_d = count[win];
            loaded_d    = count[win];
          end else begin
            remaining_d = '0;
            loaded_d    = '0;
          end
          state_d = S_WAIT_RDY;
        end
      end
      S_WAIT_RDY: begin
        if (oh_o.oh_ready && dvalid[sel_q]) begin
          out_data_d = data[sel_q];
          oh_en_d    = 1'b1;
          state_d    = S_ISSUED;
        end else if (WDOG_EN && (remaining_q < loaded_q)) begin
          // Only stalls after the first beat count toward an abort.
          if (wdog_q == WDOG_LAST) begin
            err_d         = 1'b1;
            done_d[sel_q] = 1'b1;
            gnt_d         = 2'b00;
            state_d       = S_IDLE;
          end else begin
            wdog_d = wdog_q + 32'd1;
          end
        end
      end
      S_ISSUED: begin
        state_d = S_CHECK;
      end
      S_CHECK: begin
        // The host drops oh_ready once it has taken the beat; still high means retry.
        if (oh_o.oh_ready) begin
          state_d = S_WAIT_RDY;
        end else begin
          ack_d[sel_q] = 1'b1;
          wdog_d       = '0;
          if (remaining_q == '0) begin
            done_d[sel_q] = 1'b1;
            gnt_d         = 2'b00;
            state_d       = S_IDLE;
          end else begin
            remaining_d = remaining_q - 28'd1;
            state_d     = S_NEXT;
          end
        end
      end
      S_NEXT: begin
        state_d = S_WAIT_RDY;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      gnt_q         <= 2'b00;
      last_gnt_q    <= 1'b1;
      sel_q         <= 1'b0;
      remaining_q   <= '0;
      loaded_q      <= '0;
      wdog_q        <= '0;
      oh_en_q       <= 1'b0;
      out_status_q  <= '0;
      out_address_q <= '0;
      out_count_q   <= '0;
      out_data_q    <= '0;
      ack_q         <= 2'b00;
      done_q        <= 2'b00;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      last_gnt_q    <= last_gnt_d;
      sel_q         <= sel_d;
      remaining_q   <= remaining_d;
      loaded_q      <= loaded_d;
      wdog_q        <= wdog_d;
      oh_en_q       <= oh_en_d;
      out_status_q  <= out_status_d;
      out_address_q <= out_address_d;
      out_count_q   <= out_count_d;
      out_data_q    <= out_data_d;
      ack_q         <= ack_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  assign oh_o.oh_en          = oh_en_q;
  assign oh_o.out_status     = out_status_q;
  assign oh_o.out_address    = out_address_q;
  assign oh_o.out_data_count = out_count_q;
  assign oh_o.out_data       = out_data_q;
  assign r0_i.ack            = ack_q[0];
  assign r1_i.ack            = ack_q[1];
  assign r0_i.done           = done_q[0];
  assign r1_i.done           = done_q[1];
  assign gnt_o               = gnt_q;
  assign err_o               = err_q;

endmodule

// File: tb/tb_ft_host_out_arbiter.sv
// Bench for ft_host_out_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a packet-level reference model.
module tb_ft_host_out_arbiter;
  localparam int unsigned TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ft_host_out_req_if rq0();
  ft_host_out_req_if rq1();
  ft_host_out_oh_if  oh();
  logic [1:0] gnt;
  logic       err;

  ft_host_out_arbiter #(.TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .r0_i  (rq0),
    .r1_i  (rq1),
    .oh_o  (oh),
    .gnt_o (gnt),
    .err_o (err)
  );

  // Requester and host drive values
  logic [1:0]  b_req, b_dv;
  logic [31:0] b_st [2];
  logic [31:0] b_ad [2];
  logic [27:0] b_cnt [2];
  logic [31:0] b_dat [2];
  logic        b_ready;

  assign rq0.req = b_req[0];  assign rq1.req = b_req[1];
  assign rq0.dvalid = b_dv[0]; assign rq1.dvalid = b_dv[1];
  assign rq0.status = b_st[0]; assign rq1.status = b_st[1];
  assign rq0.address = b_ad[0]; assign rq1.address = b_ad[1];
  assign rq0.data_count = b_cnt[0]; assign rq1.data_count = b_cnt[1];
  assign rq0.data = b_dat[0]; assign rq1.data = b_dat[1];
  assign oh.oh_ready = b_ready;

  logic [1:0] d_ack, d_done;
  assign d_ack  = {rq1.ack, rq0.ack};
  assign d_done = {rq1.done, rq0.done};

  // Requester packet state
  bit          rq_act [2];
  logic [31:0] rq_w [2][8];
  int          rq_idx [2];

  // Stimulus controls
  bit gen_en, dv_rand, host_rand, force_low, stall_arm;
  int reject_left, hold, burst;

  // Statistics
  int n_chk, n_fail;
  int cyc;
  int c_ohen, c_err, c_ack [2], c_done [2];
  int cyc_gnt, cyc_ohen, cyc_ack, cyc_ack0, cyc_err, cyc_done0;
  int gnt_log [$];
  logic [31:0] dat_log [$];
  logic [31:0] last_st;
  logic [1:0]  prev_gnt;
  logic        prev_ohen;

  // Reference model: the packet in flight and the expected registered outputs
  bit m_busy;
  int m_port, m_beat, m_nbeats, m_ph, m_stall, m_last;
  logic [1:0]  e_gnt, e_ack, e_done;
  logic        e_ohen, e_err;
  logic [31:0] e_st, e_ad, e_dat;
  logic [27:0] e_cnt;

  // Inputs as they stood at the most recent active edge
  logic [1:0]  p_req, p_dv;
  logic [31:0] p_st [2];
  logic [27:0] p_cnt [2];
  logic [31:0] p_ad [2];
  logic [31:0] p_dat [2];
  logic        p_ready, p_rst;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_last = 1; m_ph = 0; m_stall = 0;
    e_gnt = 0; e_ack = 0; e_done = 0; e_ohen = 0; e_err = 0;
    e_st = 0; e_ad = 0; e_dat = 0; e_cnt = 0;
  endtask

  task automatic model_step();
    e_ohen = 0; e_ack = 0; e_done = 0; e_err = 0;
    if (!m_busy) begin
      if (p_req != 2'b00) begin
        if (p_req == 2'b11) m_port = 1 - m_last;
        else                m_port = p_req[1] ? 1 : 0;
        m_last = m_port; m_busy = 1; m_beat = 0; m_ph = 0; m_stall = 0;
        m_nbeats = (p_st[m_port][7:0] == 8'hFD) ? int'(p_cnt[m_port]) + 1 : 1;
        e_gnt = (m_port == 1) ? 2'b10 : 2'b01;
        e_st = p_st[m_port]; e_ad = p_ad[m_port]; e_cnt = p_cnt[m_port];
      end
    end else begin
      case (m_ph)
        0: begin
          if (p_ready && p_dv[m_port]) begin
            e_ohen = 1; e_dat = p_dat[m_port]; m_ph = 1;
          end else if (m_beat > 0) begin
            m_stall++;
            if (m_stall == TO) begin
              e_err = 1; e_done[m_port] = 1'b1; e_gnt = 0; m_busy = 0;
            end
          end
        end
        1: m_ph = 2;
        2: begin
          if (p_ready) m_ph = 0;
          else begin
            e_ack[m_port] = 1'b1; m_stall = 0;
            if (m_beat == m_nbeats - 1) begin
              e_done[m_port] = 1'b1; e_gnt = 0; m_busy = 0;
            end else begin
              m_beat++; m_ph = 3;
            end
          end
        end
        default: m_ph = 0;
      endcase
    end
  endtask

  task automatic compare();
    int pt;
    chk("gnt", gnt, e_gnt);
    chk("oh_en", oh.oh_en, e_ohen);
    chk("ack", d_ack, e_ack);
    chk("done", d_done, e_done);
    chk("err", err, e_err);
    chk("out_status", oh.out_status, e_st);
    chk("out_address", oh.out_address, e_ad);
    chk("out_data_count", oh.out_data_count, e_cnt);
    chk("out_data", oh.out_data, e_dat);
    if (oh.oh_en) begin
      chk("oh_en_gap", prev_ohen, 1'b0);
      pt = gnt[1] ? 1 : 0;
      chk("beat_word", oh.out_data, rq_w[pt][rq_idx[pt] & 7]);
      c_ohen++; dat_log.push_back(oh.out_data); last_st = oh.out_status;
      if (cyc_ohen < 0) cyc_ohen = cyc;
    end
    if (gnt != 2'b00 && prev_gnt == 2'b00) begin
      gnt_log.push_back(gnt[1] ? 1 : 0); cyc_gnt = cyc;
    end
    for (int i = 0; i < 2; i++) begin
      if (d_ack[i]) begin
        c_ack[i]++;
        if (cyc_ack < 0) cyc_ack = cyc;
        if (i == 0 && cyc_ack0 < 0) cyc_ack0 = cyc;
      end
      if (d_done[i]) begin
        c_done[i]++;
        if (i == 0 && cyc_done0 < 0) cyc_done0 = cyc;
      end
    end
    if (err) begin
      c_err++;
      if (cyc_err < 0) cyc_err = cyc;
    end
    prev_gnt = gnt; prev_ohen = oh.oh_en;
  endtask

  task automatic load_pkt(input int i, input logic [31:0] st, input logic [31:0] ad,
                          input logic [27:0] cnt, input logic [31:0] base);
    rq_act[i] = 1; rq_idx[i] = 0;
    for (int k = 0; k < 8; k++) rq_w[i][k] = base + 32'(k);
    b_req[i] = 1'b1; b_st[i] = st; b_ad[i] = ad; b_cnt[i] = cnt;
    b_dat[i] = rq_w[i][0]; b_dv[i] = 1'b1;
  endtask

  task automatic new_random_pkt(input int i);
    logic [31:0] st;
    logic [27:0] cnt;
    int kind;
    kind = $urandom_range(0, 2);
    st = $urandom;
    cnt = 28'($urandom);
    if (kind == 0) begin
      st[7:0] = 8'hFD; cnt = 28'($urandom_range(0, 3));
    end else if (kind == 1) begin
      st[7:0] = 8'hFF;
    end else if (st[7:0] == 8'hFD) begin
      st[7:0] = 8'hFC;
    end
    load_pkt(i, st, $urandom, cnt, $urandom);
  endtask

  task automatic drive();
    if (err) begin force_low = 0; stall_arm = 0; end
    for (int i = 0; i < 2; i++) begin
      if (rq_act[i]) begin
        if (d_done[i]) begin
          rq_act[i] = 0; b_req[i] = 1'b0; b_dv[i] = 1'b0;
        end else begin
          if (d_ack[i]) begin
            rq_idx[i]++;
            if (stall_arm && i == 0) begin force_low = 1; stall_arm = 0; end
          end
          b_dat[i] = rq_w[i][rq_idx[i] & 7];
          b_dv[i] = dv_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
      end else if (gen_en && $urandom_range(0, 5) == 0) begin
        new_random_pkt(i);
      end
    end
    if (oh.oh_en) begin
      if (reject_left > 0) begin b_ready = 1'b1; reject_left--; end
      else b_ready = host_rand ? ($urandom_range(0, 3) == 0) : 1'b0;
      hold = 1;
    end else if (hold > 0) begin
      hold--;
    end else if (force_low) begin
      b_ready = 1'b0;
    end else if (host_rand) begin
      if (burst > 0) begin burst--; b_ready = 1'b0; end
      else if ($urandom_range(0, 149) == 0) begin burst = 20; b_ready = 1'b0; end
      else b_ready = ($urandom_range(0, 3) != 0);
    end else begin
      b_ready = 1'b1;
    end
  endtask

  task automatic step();
    p_req = b_req; p_dv = b_dv; p_ready = b_ready; p_rst = rst_n;
    for (int i = 0; i < 2; i++) begin
      p_st[i] = b_st[i]; p_ad[i] = b_ad[i]; p_cnt[i] = b_cnt[i]; p_dat[i] = b_dat[i];
    end
    @(posedge clk);
    cyc++;
    #1;
    drive();
    @(negedge clk);
    if (!rst_n || !p_rst) model_reset();
    else model_step();
    compare();
  endtask

  task automatic clear_stats();
    c_ohen = 0; c_err = 0; c_ack[0] = 0; c_ack[1] = 0; c_done[0] = 0; c_done[1] = 0;
    cyc_gnt = -1; cyc_ohen = -1; cyc_ack = -1; cyc_ack0 = -1; cyc_err = -1; cyc_done0 = -1;
    gnt_log.delete(); dat_log.delete(); last_st = 0;
  endtask

  task automatic run_until_done(input int port, input int target, input int budget, input string nm);
    int n;
    n = 0;
    while (c_done[port] < target && n < budget) begin
      step(); n++;
    end
    chk({nm, " cycle budget"}, (c_done[port] >= target), 1'b1);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin rq_act[i] = 0; b_req[i] = 0; b_dv[i] = 0; end
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  logic [31:0] exp_t2 [4];

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0;
    gen_en = 0; dv_rand = 0; host_rand = 0; force_low = 0; stall_arm = 0;
    reject_left = 0; hold = 0; burst = 0;
    b_req = 0; b_dv = 0; b_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      b_st[i] = 0; b_ad[i] = 0; b_cnt[i] = 0; b_dat[i] = 0; rq_act[i] = 0; rq_idx[i] = 0;
      for (int k = 0; k < 8; k++) rq_w[i][k] = 0;
    end
    prev_gnt = 0; prev_ohen = 0;
    model_reset();
    clear_stats();
    exp_t2 = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};

    // Reset state
    repeat (3) step();
    chk("reset gnt", gnt, 2'b00);
    chk("reset oh_en", oh.oh_en, 1'b0);
    chk("reset out_status", oh.out_status, 32'h0);
    chk("reset ack/done/err", {d_ack, d_done, err}, 5'b0);
    rst_n = 1'b1;

    // Port 0 ping
    clear_stats();
    load_pkt(0, 32'h0000_00FF, 32'h1234_5678, 28'd0, 32'hC0DE_0000);
    run_until_done(0, 1, 40, "ping");
    step();
    chk("ping oh_en count", c_ohen, 1);
    chk("ping out_status", last_st, 32'h0000_00FF);
    chk("ping ack count", c_ack[0], 1);
    chk("ping done count", c_done[0], 1);
    chk("ping gnt after", gnt, 2'b00);
    chk("ping oh_en latency", cyc_ohen - cyc_gnt, 1);
    chk("ping ack latency", cyc_ack - cyc_gnt, 3);

    // Port 1 multi-beat response
    clear_stats();
    load_pkt(1, 32'h0000_00FD, 32'hAAAA_0000, 28'd3, 32'h0000_00A0);
    run_until_done(1, 1, 100, "fd4");
    chk("fd4 oh_en count", c_ohen, 4);
    chk("fd4 log size", dat_log.size(), 4);
    for (int k = 0; k < 4 && k < dat_log.size(); k++) chk("fd4 out_data", dat_log[k], exp_t2[k]);
    chk("fd4 ack count", c_ack[1], 4);
    chk("fd4 done count", c_done[1], 1);

    // Round-robin from reset
    reset_pulse();
    clear_stats();
    load_pkt(0, 32'h0000_00FF, 32'h10, 28'd0, 32'h100);
    load_pkt(1, 32'h0000_00FF, 32'h20, 28'd0, 32'h200);
    run_until_done(0, 1, 60, "rr0");
    run_until_done(1, 1, 60, "rr1");
    load_pkt(0, 32'h0000_00FF, 32'h30, 28'd0, 32'h300);
    load_pkt(1, 32'h0000_00FF, 32'h40, 28'd0, 32'h400);
    run_until_done(0, 2, 60, "rr2");
    run_until_done(1, 2, 60, "rr3");
    chk("rr grant count", gnt_log.size(), 4);
    for (int k = 0; k < 4 && k < gnt_log.size(); k++) chk("rr grant order", gnt_log[k], k % 2);

    // Two rejected issues before acceptance
    clear_stats();
    reject_left = 2;
    load_pkt(0, 32'h0000_0001, 32'h0BAD_F00D, 28'h123_4567, 32'h5555_AAAA);
    run_until_done(0, 1, 80, "retry");
    chk("retry oh_en count", c_ohen, 3);
    chk("retry ack count", c_ack[0], 1);
    for (int k = 0; k < dat_log.size(); k++) chk("retry out_data", dat_log[k], 32'h5555_AAAA);

    // Watchdog abort after beat 0, then port 1 served
    clear_stats();
    stall_arm = 1;
    load_pkt(0, 32'h0000_00FD, 32'h0000_0500, 28'd2, 32'h0000_00B0);
    step();
    load_pkt(1, 32'h0000_00FF, 32'h0000_0600, 28'd0, 32'h0000_00E0);
    run_until_done(0, 1, 100, "wdog");
    run_until_done(1, 1, 60, "wdog next");
    chk("wdog err count", c_err, 1);
    chk("wdog ack count", c_ack[0], 1);
    chk("wdog abort delay", cyc_err - cyc_ack0, 17);
    chk("wdog err with done", cyc_err, cyc_done0);
    chk("wdog grant count", gnt_log.size(), 2);
    if (gnt_log.size() == 2) chk("wdog next grant", gnt_log[1], 1);

    // Reset during beat 2 of a multi-beat packet
    clear_stats();
    load_pkt(0, 32'h0000_00FD, 32'h0000_0700, 28'd3, 32'h0000_00D0);
    begin
      int n;
      n = 0;
      while (!(oh.oh_en && c_ack[0] == 2) && n < 100) begin step(); n++; end
      chk("midrst reach beat 2", (oh.oh_en && c_ack[0] == 2), 1'b1);
    end
    #3 rst_n = 1'b0;
    #1;
    chk("midrst oh_en", oh.oh_en, 1'b0);
    chk("midrst gnt", gnt, 2'b00);
    chk("midrst ack/done/err", {d_ack, d_done, err}, 5'b0);
    chk("midrst out_status", oh.out_status, 32'h0);
    chk("midrst out_address", oh.out_address, 32'h0);
    chk("midrst out_data_count", oh.out_data_count, 28'h0);
    chk("midrst out_data", oh.out_data, 32'h0);
    for (int i = 0; i < 2; i++) begin rq_act[i] = 0; b_req[i] = 0; b_dv[i] = 0; end
    load_pkt(0, 32'h0000_00FF, 32'h50, 28'd0, 32'h500);
    load_pkt(1, 32'h0000_00FF, 32'h60, 28'd0, 32'h600);
    repeat (2) step();
    clear_stats();
    rst_n = 1'b1;
    run_until_done(0, 1, 60, "postrst0");
    run_until_done(1, 1, 60, "postrst1");
    if (gnt_log.size() > 0) chk("postrst first grant", gnt_log[0], 0);
    else chk("postrst grant seen", gnt_log.size(), 2);

    // Randomized traffic with back-pressure, rejects and stall bursts
    clear_stats();
    gen_en = 1; dv_rand = 1; host_rand = 1;
    repeat (4000) step();
    gen_en = 0;
    begin
      int n;
      n = 0;
      while ((rq_act[0] || rq_act[1]) && n < 1000) begin step(); n++; end
      chk("random drain", (rq_act[0] || rq_act[1]), 1'b0);
    end
    host_rand = 0; burst = 0;
    repeat (4) step();
    chk("random traffic", (c_ohen > 50), 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
